binary2excess3: RTL and testbench



---
 rtl/binary2excess3_pkg.sv | 21 ++
 rtl/excess3_digit.sv | 18 +
 rtl/binary2excess3.sv | 46 ++++
 tb/tb_binary2excess3.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/binary2excess3_pkg.sv
// Shared constants, digit result payload and the single-digit BCD to excess-3 conversion.
package binary2excess3_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] EXCESS3_OFFSET = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] code;
    logic               err;
  } digit_res_t;

  // Code wraps modulo 16 so non-BCD digits still yield a defined value.
  function automatic digit_res_t to_excess3(input logic [DIGIT_W-1:0] d);
    digit_res_t r;
    r.code = d + EXCESS3_OFFSET;
    r.err  = (d > BCD_MAX);
    return r;
  endfunction

endpackage

// File: rtl/excess3_digit.sv
// Combinational conversion of one 4-bit digit to excess-3, with out-of-range flag.
module excess3_digit
  import binary2excess3_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] code_c,
  output logic               err_c
);

  digit_res_t res;

  always_comb begin
    res    = to_excess3(digit);
    code_c = res.code;
    err_c  = res.err;
  end

endmodule

// File: rtl/binary2excess3.sv
// Parallel multi-digit BCD to excess-3 converter with one-cycle registered output.
module binary2excess3
  import binary2excess3_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGITS*DIGIT_W-1:0] binary_in,
  output logic [DIGITS*DIGIT_W-1:0] excess3_out,
  input  logic                      in_valid,
  output logic                      out_valid,
  output logic [DIGITS-1:0]         digit_err
);

  localparam int unsigned W = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] RESET_CODE = EXCESS3_OFFSET;

  logic [W-1:0]      code_c;
  logic [DIGITS-1:0] err_c;

  // Digits convert independently; no carry crosses a digit boundary.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    excess3_digit u_digit (
      .digit  (binary_in[k*DIGIT_W +: DIGIT_W]),
      .code_c (code_c[k*DIGIT_W +: DIGIT_W]),
      .err_c  (err_c[k])
    );
  end

  // Output registers: data and flags load only on accepted input, valid pulses one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      excess3_out <= {DIGITS{RESET_CODE}};
      digit_err   <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        excess3_out <= code_c;
        digit_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_binary2excess3.sv
// Directed scoreboard bench for binary2excess3 at DIGITS=1 and DIGITS=2.
module tb_binary2excess3;

  logic       clk;
  logic       rst_n;
  logic       vin;
  logic [3:0] bin1;
  logic [7:0] bin2;
  logic [3:0] out1;
  logic [7:0] out2;
  logic       ov1, ov2;
  logic [0:0] err1;
  logic [1:0] err2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] c1;
    logic       e1;
    logic [7:0] c2;
    logic [1:0] e2;
  } exp_t;

  exp_t sb[$];
  exp_t held;

  binary2excess3 #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .binary_in(bin1), .excess3_out(out1),
    .in_valid(vin), .out_valid(ov1), .digit_err(err1)
  );

  binary2excess3 #(.DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .binary_in(bin2), .excess3_out(out2),
    .in_valid(vin), .out_valid(ov2), .digit_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_code(input logic [3:0] d);
    logic [4:0] s;
    s = {1'b0, d} + 5'd3;
    return s[3:0];
  endfunction

  function automatic logic m_err(input logic [3:0] d);
    return d >= 4'd10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.c1 = 4'h3; e.e1 = 1'b0; e.c2 = 8'h33; e.e2 = 2'b00;
    return e;
  endfunction

  task automatic check_outs(input string tag, input exp_t e, input logic v);
    check({tag, "_valid1"}, 32'(ov1), 32'(v));
    check({tag, "_valid2"}, 32'(ov2), 32'(v));
    check({tag, "_code1"}, 32'(out1), 32'(e.c1));
    check({tag, "_err1"}, 32'(err1), 32'(e.e1));
    check({tag, "_code2"}, 32'(out2), 32'(e.c2));
    check({tag, "_err2"}, 32'(err2), 32'(e.e2));
  endtask

  // Drive one cycle at the falling edge, then compare just after the rising edge.
  task automatic cycle(input string tag, input logic [3:0] b1, input logic [7:0] b2, input logic v);
    exp_t e;
    @(negedge clk);
    bin1 = b1; bin2 = b2; vin = v;
    if (v) begin
      e.c1 = m_code(b1);
      e.e1 = m_err(b1);
      e.c2 = {m_code(b2[7:4]), m_code(b2[3:0])};
      e.e2 = {m_err(b2[7:4]), m_err(b2[3:0])};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        held = sb.pop_front();
      end
    end
    check_outs(tag, held, v);
  endtask

  initial begin
    rst_n = 1'b0; vin = 1'b0; bin1 = '0; bin2 = '0;
    held = reset_exp();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", held, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      cycle("seq", 4'(i), {4'(i), 4'(9 - i)}, 1'b1);

    cycle("bcd8", 4'd8, 8'h98, 1'b1);
    cycle("bcd9", 4'd9, 8'h90, 1'b1);
    cycle("err10", 4'd10, 8'hA0, 1'b1);
    cycle("err13", 4'd13, 8'h0D, 1'b1);
    cycle("err15", 4'd15, 8'hFF, 1'b1);

    cycle("hold_load", 4'd4, 8'h47, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle("idle", 4'(i + 1), 8'h11, 1'b0);

    // Mid-stream reset: pending input is dropped, outputs clear immediately.
    cycle("pre_rst", 4'd6, 8'h62, 1'b1);
    @(negedge clk);
    bin1 = 4'd7; bin2 = 8'h77; vin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    held = reset_exp();
    check_outs("async_rst", held, 1'b0);
    @(posedge clk);
    #1;
    check_outs("in_rst", held, 1'b0);
    @(negedge clk);
    vin = 1'b0;
    rst_n = 1'b1;

    cycle("post_rst", 4'd2, 8'h59, 1'b1);
    cycle("two_dig", 4'd3, 8'hA3, 1'b1);
    cycle("gap", 4'd0, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++)
      cycle("rand", 4'($urandom_range(15)), 8'($urandom_range(255)), 1'($urandom_range(1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
